// File: rtl/tl_arb_pkg.sv
// Shared types and helpers for the burst-locking round-robin arbiters.
// rr_pick is the behavioural reference for the tl_rr_pick datapath.
package tl_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int NREQ_DEF   = 3;
  localparam int BEAT_W_DEF = 4;
  localparam int PTR_W      = $clog2(NREQ_DEF);
  localparam int MAXN       = 8;
  localparam int MAXP       = 3;

  // First set bit scanning ptr, ptr+1, ... modulo n.
  function automatic logic [MAXN-1:0] rr_pick(
    input logic [MAXN-1:0] req,
    input logic [MAXP-1:0] ptr,
    input int unsigned     n
  );
    logic [MAXN-1:0] gnt;
    logic [MAXP-1:0] idx;
    logic            done;
    gnt  = '0;
    done = 1'b0;
    for (int unsigned k = 0; k < MAXN; k++) begin
      idx = MAXP'((32'(ptr) + k) % n);
      if (!done && (k < n) && req[idx]) begin
        gnt[idx] = 1'b1;
        done     = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin picker: rotate by ptr, isolate the lowest
// set bit, rotate back. Output is one-hot or zero.
module tl_rr_pick
  import tl_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [NREQ-1:0]   w_pe;

  assign w_dbl = {req, req};
  assign w_rot = NREQ'(w_dbl >> ptr);
  assign w_pe  = w_rot & (~w_rot + NREQ'(1));
  assign gnt   = NREQ'(({w_pe, w_pe} << ptr) >> NREQ);

endmodule

// File: rtl/tl_beat_rr_arbiter.sv
// Round-robin arbiter that locks the shared channel to one requester
// for a whole multi-beat burst, with a registered grant decision.
module tl_beat_rr_arbiter
  import tl_arb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int BEAT_W = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*BEAT_W-1:0] req_beats,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NREQ-1:0]        out_sel,
  output logic                   out_last,
  output logic                   busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        r_state, w_nstate;
  logic [NREQ-1:0]   r_sel, w_nsel;
  logic [BEAT_W-1:0] r_cnt, w_ncnt;
  logic [PW-1:0]     r_ptr, w_nptr;
  logic [PW-1:0]     r_own, w_nown;

  logic [NREQ-1:0]   w_gnt;
  logic [PW-1:0]     w_win_idx;
  logic [BEAT_W-1:0] w_win_beats;
  logic              w_lock;
  logic              w_fire;

  tl_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  always_comb begin
    w_win_idx   = '0;
    w_win_beats = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_win_idx   = PW'(i);
        w_win_beats = req_beats[i*BEAT_W +: BEAT_W];
      end
    end
  end

  assign w_lock    = (r_state == LOCK);
  assign busy      = w_lock;
  assign out_sel   = r_sel;
  assign out_valid = w_lock && |(req_valid & r_sel);
  assign req_ready = w_lock ? (r_sel & {NREQ{out_ready}}) : '0;
  assign out_last  = w_lock && (r_cnt == '0);
  assign w_fire    = out_valid && out_ready;

  always_comb begin
    w_nstate = r_state;
    w_nsel   = r_sel;
    w_ncnt   = r_cnt;
    w_nptr   = r_ptr;
    w_nown   = r_own;
    unique case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_nstate = LOCK;
          w_nsel   = w_gnt;
          w_ncnt   = w_win_beats;
          w_nown   = w_win_idx;
        end
      end
      LOCK: begin
        // A fire on the last beat always leaves LOCK; no underflow path.
        if (w_fire) begin
          if (r_cnt == '0) begin
            w_nstate = IDLE;
            w_nsel   = '0;
            w_nptr   = (r_own == PW'(NREQ-1)) ? '0 : r_own + PW'(1);
          end else begin
            w_ncnt = r_cnt - BEAT_W'(1);
          end
        end
      end
      default: begin
        w_nstate = IDLE;
        w_nsel   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_own   <= '0;
    end else begin
      r_state <= w_nstate;
      r_sel   <= w_nsel;
      r_cnt   <= w_ncnt;
      r_ptr   <= w_nptr;
      r_own   <= w_nown;
    end
  end

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(r_sel));
  a_idle_sel: assert property (@(posedge clock) disable iff (!reset_n)
    ((r_sel == '0) == (r_state == IDLE)));
  a_ready_own: assert property (@(posedge clock) disable iff (!reset_n)
    ((req_ready & ~r_sel) == '0));
`endif

endmodule

// File: tb/tb_tl_beat_rr_arbiter.sv
// Directed bench for tl_beat_rr_arbiter: reset, single burst, wrap,
// fairness, backpressure with valid drop, reset mid-burst, max burst.
module tb_tl_beat_rr_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [11:0] req_beats;
  logic [2:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_sel;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  tl_beat_rr_arbiter #(
    .NREQ   (3),
    .BEAT_W (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_beats (req_beats),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // Inputs change at edge+2, outputs are sampled at edge+3.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Counts fires until the arbiter leaves LOCK or the budget expires.
  task automatic drain(input int maxc, output int nf,
                       output int last_fire, output int last_cnt);
    nf = 0;
    last_fire = -1;
    last_cnt = 0;
    for (int c = 0; c < maxc; c++) begin
      #1;
      if (!busy) break;
      if (out_valid && out_ready) begin
        nf++;
        if (out_last) begin
          last_cnt++;
          last_fire = nf;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = '0;
    req_beats = '0;
    out_ready = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if ({out_sel, busy, out_valid, out_last, req_ready} !== 9'b0) begin
      errors++;
      $display("FAIL reset: sel=%b busy=%b ov=%b last=%b rdy=%b need all 0",
               out_sel, busy, out_valid, out_last, req_ready);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int nf, lf, lc;
    req_valid = 3'b010;
    req_beats = {4'd0, 4'd2, 4'd0};
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sel !== 3'b000) begin
      errors++;
      $display("FAIL single_idle: ov=%b sel=%b need 0/000",
               out_valid, out_sel);
    end
    tick();
    #1;
    checks++;
    if (out_sel !== 3'b010 || req_ready !== 3'b010) begin
      errors++;
      $display("FAIL single_grant: sel=%b rdy=%b need 010/010",
               out_sel, req_ready);
    end
    drain(10, nf, lf, lc);
    checks++;
    if (nf != 3 || lf != 3 || lc != 1) begin
      errors++;
      $display("FAIL single_fires: fires=%0d last_at=%0d lasts=%0d need 3/3/1",
               nf, lf, lc);
    end
    req_valid = 3'b000;
    #1;
    checks++;
    if (busy !== 1'b0 || out_sel !== 3'b000) begin
      errors++;
      $display("FAIL single_end: busy=%b sel=%b need 0/000", busy, out_sel);
    end
  endtask

  task automatic test_wrap();
    req_valid = 3'b011;
    req_beats = '0;
    tick();
    #1;
    checks++;
    if (out_sel !== 3'b001) begin
      errors++;
      $display("FAIL wrap_grant: sel=%b need 001", out_sel);
    end
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: busy=%b need 0", busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    exp_g[0] = 3'b001;
    exp_g[1] = 3'b010;
    exp_g[2] = 3'b100;
    exp_g[3] = 3'b001;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req_valid = 3'b111;
    req_beats = '0;
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      checks++;
      if (busy !== 1'b0 || out_sel !== 3'b000) begin
        errors++;
        $display("FAIL rr_bubble%0d: busy=%b sel=%b need 0/000",
                 g, busy, out_sel);
      end
      tick();
      #1;
      checks++;
      if (out_sel !== exp_g[g] || out_last !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d: sel=%b last=%b need %b/1",
                 g, out_sel, out_last, exp_g[g]);
      end
      tick();
    end
    req_valid = 3'b000;
  endtask

  task automatic test_backpressure();
    logic [2:0] v_tab [6];
    logic       r_tab [6];
    logic       l_tab [6];
    int nf;
    v_tab = '{3'b111, 3'b111, 3'b110, 3'b110, 3'b111, 3'b111};
    r_tab = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    l_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    nf = 0;
    req_valid = 3'b001;
    req_beats = {4'd0, 4'd0, 4'd1};
    out_ready = 1'b0;
    tick();
    for (int c = 0; c < 6; c++) begin
      req_valid = v_tab[c];
      out_ready = r_tab[c];
      #1;
      checks++;
      if (out_sel !== 3'b001 || (req_ready & 3'b110) !== 3'b000 ||
          out_valid !== v_tab[c][0] || out_last !== l_tab[c]) begin
        errors++;
        $display("FAIL bp_cyc%0d: sel=%b rdy=%b ov=%b last=%b need 001/x00/%b/%b",
                 c, out_sel, req_ready, out_valid, out_last,
                 v_tab[c][0], l_tab[c]);
      end
      if (out_valid && out_ready) nf++;
      tick();
    end
    req_valid = 3'b000;
    #1;
    checks++;
    if (nf != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_fires: fires=%0d busy=%b need 2/0", nf, busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    int nf, lf, lc;
    req_valid = 3'b010;
    req_beats = {4'd0, 4'd3, 4'd0};
    out_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req_valid = 3'b011;
    req_beats = '0;
    #1;
    checks++;
    if (out_sel !== 3'b000 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: sel=%b busy=%b ov=%b need 000/0/0",
               out_sel, busy, out_valid);
    end
    tick();
    #1;
    checks++;
    if (out_sel !== 3'b001) begin
      errors++;
      $display("FAIL rst_ptr: sel=%b need 001", out_sel);
    end
    tick();
    req_valid = 3'b100;
    req_beats = {4'd3, 4'd0, 4'd0};
    tick();
    #1;
    checks++;
    if (out_sel !== 3'b100) begin
      errors++;
      $display("FAIL rst_new_grant: sel=%b need 100", out_sel);
    end
    req_beats = '0;
    drain(12, nf, lf, lc);
    checks++;
    if (nf != 4 || lf != 4 || lc != 1) begin
      errors++;
      $display("FAIL rst_new_fires: fires=%0d last_at=%0d lasts=%0d need 4/4/1",
               nf, lf, lc);
    end
    req_valid = 3'b000;
  endtask

  task automatic test_max_burst();
    int nf, lf, lc;
    req_valid = 3'b001;
    req_beats = {4'd0, 4'd0, 4'hF};
    out_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (out_sel !== 3'b001) begin
      errors++;
      $display("FAIL max_grant: sel=%b need 001", out_sel);
    end
    drain(40, nf, lf, lc);
    checks++;
    if (nf != 16 || lf != 16 || lc != 1) begin
      errors++;
      $display("FAIL max_fires: fires=%0d last_at=%0d lasts=%0d need 16/16/1",
               nf, lf, lc);
    end
    req_valid = 3'b000;
    #1;
    checks++;
    if (busy !== 1'b0 || out_sel !== 3'b000) begin
      errors++;
      $display("FAIL max_end: busy=%b sel=%b need 0/000", busy, out_sel);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid_burst();
    test_max_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_beat_rr_arbiter.md
Name: tl_beat_rr_arbiter

Overview:
- Locks a single shared downstream channel to one of NREQ requesters for a whole multi-beat burst.
- Round-robin arbiter with burst lock, sitting in front of the shared channel in the E21 bus fabric.
- Grant vector is at-most-one-hot by construction; the existing pairwise grant-exclusion checker in the testbench attaches to out_sel.
- Arbitration is registered: one decision cycle per burst, then beats stream with valid/ready until the last beat.

Parameters:
- NREQ, 3, number of requesters (2..8).
- BEAT_W, 4, width of burst-length field; a burst is 1..2^BEAT_W beats.

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on clock rising edge.
- req_valid  input  NREQ  per-requester beat valid; bit i = requester i.
- req_beats  input  NREQ*BEAT_W  per-requester burst length minus 1; slice i is [i*BEAT_W +: BEAT_W]; sampled only at grant.
- req_ready  output  NREQ  per-requester beat accept.
- out_valid  output  1  beat valid to the shared channel.
- out_ready  input  1  shared channel accepts the beat.
- out_sel  output  NREQ  one-hot owner of the channel, or all zero when idle; drives the downstream data mux.
- out_last  output  1  the current beat is the final beat of the burst.
- busy  output  1  the FSM is in LOCK.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, out_sel=0, beat counter=0, priority pointer=0 (requester 0 highest).
  - All outputs low.
  - Reset wins over every other event in the same cycle, including mid-burst; an aborted burst is dropped with no completion.
- FSM states: IDLE, LOCK.
- IDLE:
  - out_valid=0, req_ready=0, out_sel=0.
  - If any req_valid bit is set, select the first set bit scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - Next edge: out_sel <= onehot(winner), cnt <= req_beats[winner], state <= LOCK.
  - Grant-to-first-beat latency: 1 cycle after the request is seen.
- LOCK:
  - out_valid = |(req_valid & out_sel).
  - req_ready = out_sel & {NREQ{out_ready}}; non-owners see ready=0.
  - out_last = (cnt==0).
  - A beat fires when out_valid & out_ready.
  - On a fire with cnt!=0: cnt <= cnt-1.
  - On a fire with cnt==0: state <= IDLE, out_sel <= 0, ptr <= (winner+1) mod NREQ.
- The owner may drop req_valid mid-burst. The lock holds: no beat is counted and no other requester is granted.
- Requests from non-owners during LOCK are ignored. They are re-evaluated in IDLE using the updated pointer.
- There is always exactly one IDLE bubble cycle between bursts, even when requests are continuous.
- Counter arithmetic is unsigned BEAT_W bits, with no underflow: cnt==0 with a fire always exits LOCK.
- req_beats changes after grant have no effect on the current burst.
- Invariants, checked with assertions under `ifndef SYNTHESIS`:
  - $onehot0(out_sel) every cycle.
  - out_sel==0 if and only if state==IDLE.
  - req_ready & ~out_sel == 0.

Decomposition:
- Package tl_arb_pkg:
  - enum arb_state_e {IDLE, LOCK}.
  - Function rr_pick(req, ptr) returning the one-hot winner.
  - Localparam PTR_W = $clog2(NREQ).
- One sub-module, tl_rr_pick: combinational rotate, priority-encode, unrotate.
  - Inputs: req, ptr.
  - Output: one-hot gnt.
  - Reused by other fabric arbiters.
- The FSM, counter and pointer live in tl_beat_rr_arbiter.

Test Plan:
- Single burst: after reset, req_valid=3'b010 with beats[1]=2 and out_ready=1 held.
  - Expect out_sel=010 one cycle later.
  - Expect 3 fires; out_last only on the third.
  - Expect IDLE on the next cycle; ptr=2.
- Round-robin fairness: req_valid=3'b111 held, all beats=0, out_ready=1.
  - Expect grants in the order 001, 010, 100, 001, ...
  - Expect each grant separated by one IDLE cycle.
- Backpressure and valid drop: owner 0, beats=1.
  - Toggle out_ready 0/1 and drop req_valid for 2 cycles mid-burst.
  - Expect exactly 2 fires, out_sel unchanged throughout, and req_ready[1..2]=0 throughout.
- Wrap-around: ptr=2 after serving requester 1, then req_valid=3'b011.
  - Expect requester 0 granted, not requester 1.
- Reset mid-burst: reset_n=0 for 1 cycle during beat 2 of 4.
  - Next cycle expect out_sel=0, busy=0, ptr=0.
  - A new request from requester 2 is granted with a full beat count.
- Max burst: beats=4'hF.
  - Expect 16 fires, with out_last on the 16th only.
  - Expect the $onehot0(out_sel) assertion never to fire.
